// File: rtl/bcd_scan_pkg.sv
// Shared constants and helpers for the multiplexed BCD display driver.
//   BCD_W       : bits per digit
//   BLANK_CODE  : code the decoder renders as all segments off
//   MAX_DIGITS  : widest digit count the helper functions support
//   onehot()    : one-hot digit enable for a digit index
//   lz_mask()   : per-digit leading-zero blank flags (used when BCD_SCAN_LZ_BLANK_EN is defined)
package bcd_scan_pkg;

  localparam int unsigned     BCD_W      = 4;
  localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;
  localparam int unsigned     MAX_DIGITS = 16;
  localparam int unsigned     WORD_MAX_W = MAX_DIGITS * BCD_W;

  // One-hot vector with bit idx set; bits at or above n stay clear.
  function automatic logic [MAX_DIGITS-1:0] onehot(input int unsigned idx,
                                                   input int unsigned n);
    logic [MAX_DIGITS-1:0] res;
    res = '0;
    for (int unsigned i = 0; i < MAX_DIGITS; i++) begin
      res[i] = (i == idx) && (i < n);
    end
    return res;
  endfunction

  // Flag digit i (i>0) when it and every more-significant digit are zero.
  // Digit 0 is never flagged so a zero value still shows one digit.
  function automatic logic [MAX_DIGITS-1:0] lz_mask(input logic [WORD_MAX_W-1:0] word,
                                                    input int unsigned n);
    logic [MAX_DIGITS-1:0] res;
    logic                  zero_run;
    res      = '0;
    zero_run = 1'b1;
    for (int unsigned i = MAX_DIGITS - 1; i > 0; i--) begin
      if (i < n) begin
        zero_run = zero_run && (word[i*BCD_W +: BCD_W] == 4'h0);
        res[i]   = zero_run;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Digit-slot prescaler: counts 0..SCAN_DIV-1 and flags the last count.
//   clk  : system clock, rising edge
//   rst  : synchronous active-high reset (counter to 0)
//   tick : high during the final cycle of each digit slot (combinational)
module scan_tick_gen #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned        CNT_W    = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(SCAN_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Wrap explicitly so non-power-of-two dividers work.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_scan_driver.sv
// Time-multiplexed 7-segment display driver with a double-buffered digit word.
// A new word is captured into a pending buffer over valid/ready and only
// becomes the displayed (active) word at a frame start, so a frame never tears.
//   clk, rst    : clock and synchronous active-high reset
//   in_valid    : digits_in holds a word to load
//   in_ready    : pending buffer is empty and can take a word
//   digits_in   : packed BCD word, digit 0 in the low nibble
//   bcd_out     : code of the lit digit, to the bcd_2_7_seg decoder
//   an          : one-hot digit enable (inverted when ANODE_ACTIVE_LOW)
//   digit_idx   : index of the lit digit
//   frame_tick  : one-cycle pulse when digit 0 is lit at a frame start
// Optional build macro BCD_SCAN_LZ_BLANK_EN enables leading-zero blanking.
module bcd_scan_driver
  import bcd_scan_pkg::*;
#(
  parameter int unsigned NUM_DIGITS       = 4,
  parameter int unsigned SCAN_DIV         = 50000,
  parameter bit          ANODE_ACTIVE_LOW = 1'b0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_DIGITS*BCD_W-1:0]   digits_in,
  output logic [BCD_W-1:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]         an,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_tick
);

  localparam int unsigned           IDX_W    = $clog2(NUM_DIGITS);
  localparam int unsigned           WORD_W   = NUM_DIGITS * BCD_W;
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = {NUM_DIGITS{ANODE_ACTIVE_LOW}};

  logic tick;

  logic [WORD_W-1:0]     active_q,   active_d;
  logic [WORD_W-1:0]     pending_q,  pending_d;
  logic                  in_ready_q, in_ready_d;   // low means pending is full
  logic [IDX_W-1:0]      idx_q,      idx_d;
  logic [NUM_DIGITS-1:0] an_q,       an_d;
  logic [BCD_W-1:0]      bcd_q,      bcd_d;
  logic                  frame_q,    frame_d;

  logic [IDX_W-1:0]  idx_nxt;
  logic              frame_start;
  logic              apply;
  logic [WORD_W-1:0] word_nxt;
  logic [WORD_W-1:0] disp_word;
`ifdef BCD_SCAN_LZ_BLANK_EN
  logic [NUM_DIGITS-1:0] blank;
`endif

  scan_tick_gen #(
    .SCAN_DIV (SCAN_DIV)
  ) u_tick (
    .clk  (clk),
    .rst  (rst),
    .tick (tick)
  );

  // Next-state: handshake, buffer swap at frame start, and slot outputs.
  always_comb begin
    active_d   = active_q;
    pending_d  = pending_q;
    in_ready_d = in_ready_q;
    idx_d      = idx_q;
    an_d       = an_q;
    bcd_d      = bcd_q;
    frame_d    = 1'b0;

    idx_nxt     = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    frame_start = tick && (idx_q == IDX_LAST);
    apply       = frame_start && !in_ready_q;
    // Digit 0 of a new frame must come from the word being applied this edge.
    word_nxt    = apply ? pending_q : active_q;

    disp_word = word_nxt;
`ifdef BCD_SCAN_LZ_BLANK_EN
    blank = NUM_DIGITS'(lz_mask(WORD_MAX_W'(word_nxt), NUM_DIGITS));
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (blank[i]) begin
        disp_word[i*BCD_W +: BCD_W] = BLANK_CODE;
      end
    end
`endif

    // Transfer and apply are exclusive: one needs pending empty, the other full.
    if (in_valid && in_ready_q) begin
      pending_d  = digits_in;
      in_ready_d = 1'b0;
    end
    if (apply) begin
      active_d   = pending_q;
      in_ready_d = 1'b1;
    end

    if (tick) begin
      idx_d   = idx_nxt;
      an_d    = NUM_DIGITS'(onehot(32'(idx_nxt), NUM_DIGITS)) ^ AN_OFF;
      frame_d = frame_start;
      bcd_d   = BLANK_CODE;
      for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
        if (idx_nxt == IDX_W'(i)) begin
          bcd_d = disp_word[i*BCD_W +: BCD_W];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      active_q   <= {NUM_DIGITS{BLANK_CODE}};
      pending_q  <= '0;
      in_ready_q <= 1'b1;
      idx_q      <= IDX_LAST;
      an_q       <= AN_OFF;
      bcd_q      <= BLANK_CODE;
      frame_q    <= 1'b0;
    end else begin
      active_q   <= active_d;
      pending_q  <= pending_d;
      in_ready_q <= in_ready_d;
      idx_q      <= idx_d;
      an_q       <= an_d;
      bcd_q      <= bcd_d;
      frame_q    <= frame_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign bcd_out    = bcd_q;
  assign an         = an_q;
  assign digit_idx  = idx_q;
  assign frame_tick = frame_q;

endmodule

// File: tb/tb_bcd_scan_driver.sv
// Scoreboard bench for bcd_scan_driver (NUM_DIGITS=4, SCAN_DIV=4).
// Expected per-slot records are queued from the word each frame should show
// and popped as the DUT presents each digit slot.
module tb_bcd_scan_driver;

  localparam int unsigned ND = 4;
  localparam int unsigned SD = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        in_ready;
  logic [3:0]  bcd_out;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_tick;

  int unsigned cyc;
  int          errors = 0;
  int          checks = 0;

  typedef struct packed {
    logic [3:0] bcd;
    logic [3:0] an;
    logic [1:0] idx;
    logic       ft;
  } slot_t;

  slot_t sb[$];

  bcd_scan_driver #(
    .NUM_DIGITS       (ND),
    .SCAN_DIV         (SD),
    .ANODE_ACTIVE_LOW (1'b0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .digits_in  (digits_in),
    .bcd_out    (bcd_out),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  // Edges since reset release; frame starts land on cyc % 16 == 4.
  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Word as it should appear on the display.
  function automatic logic [15:0] disp(input logic [15:0] w);
    logic [15:0] r;
    r = w;
`ifdef BCD_SCAN_LZ_BLANK_EN
    begin
      bit nz;
      nz = 1'b0;
      for (int i = 3; i >= 1; i--) begin
        if (4'(w >> (4 * i)) != 4'h0) nz = 1'b1;
        if (!nz) r = r | (16'hF << (4 * i));
      end
    end
`endif
    return r;
  endfunction

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".an"},    32'(an),         32'h0);
    check({tag, ".bcd"},   32'(bcd_out),    32'hF);
    check({tag, ".idx"},   32'(digit_idx),  32'd3);
    check({tag, ".ready"}, 32'(in_ready),   32'd1);
    check({tag, ".ft"},    32'(frame_tick), 32'd0);
  endtask

  task automatic goto_frame_start();
    for (int i = 0; i < 40; i++) begin
      step(1);
      if (cyc % 16 == 4) return;
    end
    check("sync_timeout", 32'd0, 32'd1);
  endtask

  // Called just after a frame-start edge; returns just after the next one.
  task automatic check_frame(input logic [15:0] w, input string tag);
    logic [15:0] e;
    slot_t       r;
    e = disp(w);
    for (int s = 0; s < 4; s++) begin
      sb.push_back('{bcd: 4'(e >> (4 * s)), an: 4'(1 << s), idx: 2'(s), ft: (s == 0)});
    end
    for (int s = 0; s < 4; s++) begin
      if (sb.size() == 0) begin
        check($sformatf("%s.s%0d.empty", tag, s), 32'd0, 32'd1);
      end else begin
        r = sb.pop_front();
        check($sformatf("%s.s%0d.bcd", tag, s),  32'(bcd_out),    32'(r.bcd));
        check($sformatf("%s.s%0d.an", tag, s),   32'(an),         32'(r.an));
        check($sformatf("%s.s%0d.idx", tag, s),  32'(digit_idx),  32'(r.idx));
        check($sformatf("%s.s%0d.ft", tag, s),   32'(frame_tick), 32'(r.ft));
        step(3);
        check($sformatf("%s.s%0d.hold_bcd", tag, s), 32'(bcd_out),    32'(r.bcd));
        check($sformatf("%s.s%0d.hold_an", tag, s),  32'(an),         32'(r.an));
        check($sformatf("%s.s%0d.hold_ft", tag, s),  32'(frame_tick), 32'd0);
        step(1);
      end
    end
  endtask

  task automatic load(input logic [15:0] w, input string tag);
    check({tag, ".ready_before"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid  = 1'b1;
    digits_in = w;
    @(posedge clk);
    #1;
    check({tag, ".ready_after"}, 32'(in_ready), 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic load_next(input logic [15:0] prev, input logic [15:0] w, input string tag);
    fork
      check_frame(prev, {tag, ".prev"});
      begin
        step(2);
        load(w, {tag, ".load"});
      end
    join
    check_frame(w, tag);
  endtask

  initial begin
    // Reset state and first frame
    rst = 1'b1;
    step(1);
    check_reset("rst0");
    step(1);
    @(negedge clk);
    rst = 1'b0;
    step(3);
    check("boot.pre_an", 32'(an),         32'h0);
    check("boot.pre_ft", 32'(frame_tick), 32'd0);
    goto_frame_start();
    check_frame(16'hFFFF, "boot");

    // Load mid-frame: not visible until the next frame start
    fork
      check_frame(16'hFFFF, "pre1234");
      begin
        step(5);
        check("l1234.idx1", 32'(digit_idx), 32'd1);
        load(16'h1234, "l1234");
      end
    join
    check_frame(16'h1234, "f1234");

    // Back-pressure: second word waits for the pending slot to free up
    fork
      check_frame(16'h1234, "bp0");
      begin
        @(negedge clk);
        in_valid  = 1'b1;
        digits_in = 16'h1111;
        step(1);
        check("bp.take1", 32'(in_ready), 32'd0);
        @(negedge clk);
        digits_in = 16'h2222;
        for (int i = 0; i < 3; i++) begin
          step(2);
          check("bp.hold", 32'(in_ready), 32'd0);
        end
      end
    join
    fork
      check_frame(16'h1111, "bp1");
      begin
        check("bp.reopen", 32'(in_ready), 32'd1);
        step(1);
        check("bp.take2", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
      end
    join
    check_frame(16'h2222, "bp2");

    // Transfer exactly on a frame-start edge lands one frame later
    fork
      check_frame(16'h2222, "col_prev");
      begin
        step(15);
        @(negedge clk);
        in_valid  = 1'b1;
        digits_in = 16'h5678;
        @(posedge clk);
        #1;
      end
    join
    fork
      check_frame(16'h2222, "colN");
      begin
        check("col.took", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b0;
      end
    join
    check_frame(16'h5678, "colN1");

    // Zero patterns (blanked only when the blanking build is enabled)
    load_next(16'h5678, 16'h0042, "w0042");
    load_next(16'h0042, 16'h0000, "w0000");
    load_next(16'h0000, 16'h1002, "w1002");
    // Non-BCD codes pass through
    load_next(16'h1002, 16'hA9F0, "wA9F0");

    // Reset mid-frame with pending full, spanning a would-be frame start
    load(16'h7777, "rst.load");
    step(8);
    check("rst.pre_bcd", 32'(bcd_out), 32'h9);
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step(1);
      check_reset($sformatf("rst.in%0d", i));
    end
    @(negedge clk);
    rst = 1'b0;
    goto_frame_start();
    check_frame(16'hFFFF, "postrst");
    check_frame(16'hFFFF, "postrst2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
